gpr_wb_sched: RTL and testbench
===============================

# gpr_wb_sched

Register-file write-back scheduler and scoreboard for the NPC integer core. It tracks in-flight writes to the GPRs, stalls decode on RAW/WAW hazards and when the outstanding-load limit is reached, and arbitrates the register file's single write port between execute results and returning load data. It sits between decode/execute/LSU and `regs`, and drives the `regs` write port (`wen_i`, `rd_i`, `e_wdata_i`, with `is_load_i` tied low).

## Interface
Parameters:
- `XLEN`, 64, data width of register contents
- `LDQ_DEPTH`, 4, maximum outstanding loads; power of two, ≥2

Ports (reset is asynchronous, active-low; clock is `clk_i`, reset is `rst_i`):
- `clk_i`  in  1  core clock
- `rst_i`  in  1  async active-low reset
- `id_valid_i`  in  1  decode presents an instruction
- `id_rs1_i`, `id_rs2_i`  in  5  source register indices
- `id_rd_i`  in  5  destination index
- `id_wen_i`  in  1  instruction writes `rd`
- `id_is_load_i`  in  1  instruction is a load
- `id_stall_o`  out  1  hold decode; combinational
- `ex_valid_i`  in  1  execute result ready (non-load writers only)
- `ex_rd_i`  in  5  result destination
- `ex_wdata_i`  in  XLEN  result data
- `ld_valid_i`  in  1  LSU returns load data (in program order)
- `ld_data_i`  in  XLEN  load data
- `ld_ready_o`  out  1  scheduler accepts load data; combinational
- `rf_wen_o`  out  1  register file write enable; registered
- `rf_rd_o`  out  5  register file write index; registered
- `rf_wdata_o`  out  XLEN  register file write data; registered

## Operation
- State: `pending[31:1]` bit vector; rd-tag FIFO (`LDQ_DEPTH` × 5 bits, rd/wr pointers plus count); output write register.
- Hazard: `id_stall_o = id_valid_i && (hit(rs1) || hit(rs2) || (id_wen_i && hit(rd)) || (id_is_load_i && ldq_full))`, where `hit(r) = r!=0 && pending[r]`.
- Issue (`id_valid_i && !id_stall_o`):
  - If `id_wen_i && rd!=0`, set `pending[rd]`.
  - If `id_is_load_i`, push `rd` to the FIFO, including rd=0, so the return is consumed.
- Arbitration: execute has strict priority. `ld_ready_o = (count!=0) && !ex_valid_i`.
- Execute accept: `ex_valid_i` registers `rf_wen_o = (ex_rd_i!=0)`, `rf_rd_o = ex_rd_i`, `rf_wdata_o = ex_wdata_i`.
- Load accept (`ld_valid_i && ld_ready_o`): pop the FIFO head as rd and register the write the same way with `ld_data_i`.
- `ld_valid_i` while the FIFO is empty: ignored; no write, state unchanged.
- `pending[rf_rd_o]` is cleared on the edge where `rf_wen_o=1`, which is the same edge on which `regs` commits the data.
- Set and clear of the same index in one cycle cannot occur, because issue stalls on a pending rd.
- Push and pop in the same cycle: count is unchanged and both pointers advance, wrapping modulo `LDQ_DEPTH`.
- x0 is never pending and is never written.

## Timing
- Reset values: `rf_wen_o=0`, `rf_rd_o=0`, `rf_wdata_o=0`, `pending=0`, FIFO empty.
- Combinational reset effects: `ld_ready_o=0` and `id_stall_o=0`.
- Reset mid-operation discards all in-flight state. Returns arriving after reset are ignored because `ld_ready_o=0`.
- Latency: one cycle from ex/ld accept to `rf_wen_o`.
- A dependent instruction issues two cycles after its producer's accept.
- `ld_valid_i`/`ld_data_i` are held by the LSU until `ld_ready_o=1`.
- `id_stall_o` and `ld_ready_o` have no combinational path from each other.

## Configuration
- `YSYX_23060251_SB_PERF_EN`:
  - Defined: adds output `sb_stall_cnt_o` [31:0], counting cycles with `id_stall_o=1`. It resets to 0 and wraps at 2^32.
  - Undefined: the port and counter are absent.

## Structure
- Shared defines header: register-index bus `ysyx_23060251_rs_bus`, `ysyx_23060251_reg_zero`, `ysyx_23060251_reg_num`.
- One sub-module, `sb_tag_fifo`: parameterised depth/width FIFO with push, pop, full, empty and head outputs, and async active-low reset.

## Test plan
- Reset:
  - Stimulus: hold `rst_i=0` with random inputs.
  - Required: all outputs 0 and `id_stall_o=0`.
  - Stimulus: release reset, then issue `id_rs1_i=7`.
  - Required: no stall.
- ALU RAW:
  - Stimulus: issue `rd=5` with wen, then `rs1=5` the next cycle.
  - Required: stall=1 until `ex_valid_i` with rd=5 and data 0x1234; then `rf_wen_o=1`, `rf_rd_o=5`, `rf_wdata_o=0x1234` one cycle later; stall drops the cycle after that.
- Load limit:
  - Stimulus: issue 4 loads to x1–x4.
  - Required: a 5th load stalls.
  - Stimulus: return `ld_data_i=0xDEAD`.
  - Required: write to x1 with 0xDEAD; the 5th load issues on the next cycle.
- Collision:
  - Stimulus: `ex_valid_i` (rd=3, 0xAA) and `ld_valid_i` (head rd=4, 0xBB) asserted in the same cycle.
  - Required: `ld_ready_o=0`; x3 written first, x4 written one cycle later.
- x0 load:
  - Stimulus: issue a load with rd=0, then return data.
  - Required: `ld_ready_o=1`, FIFO pops, `rf_wen_o` stays 0, no stall.
- Async reset mid-flight:
  - Stimulus: 2 loads outstanding, pulse `rst_i` low off-edge.
  - Required: pending and FIFO cleared immediately; a later `ld_valid_i` produces no write.

Source files
------------

// File: rtl/gpr_wb_sched_pkg.sv
// rtl/gpr_wb_sched_pkg.sv - shared register-index types and hazard helper for the write-back scheduler
package gpr_wb_sched_pkg;

    typedef logic [4:0] ysyx_23060251_rs_bus;

    localparam ysyx_23060251_rs_bus ysyx_23060251_reg_zero = 5'd0;
    localparam int                  ysyx_23060251_reg_num  = 32;

    // x0 is never pending, so a zero index never hits regardless of the vector.
    function automatic logic reg_hit(input logic [ysyx_23060251_reg_num-1:0] pend,
                                     input ysyx_23060251_rs_bus r);
        return (r != ysyx_23060251_reg_zero) && pend[r];
    endfunction

endpackage

// File: rtl/gpr_wb_sched_if.sv
// rtl/gpr_wb_sched_if.sv - decode/execute/LSU/regfile signal bundle for gpr_wb_sched
interface gpr_wb_sched_if #(
    parameter int XLEN = 64
);
    logic            id_valid_i;
    logic [4:0]      id_rs1_i;
    logic [4:0]      id_rs2_i;
    logic [4:0]      id_rd_i;
    logic            id_wen_i;
    logic            id_is_load_i;
    logic            id_stall_o;
    logic            ex_valid_i;
    logic [4:0]      ex_rd_i;
    logic [XLEN-1:0] ex_wdata_i;
    logic            ld_valid_i;
    logic [XLEN-1:0] ld_data_i;
    logic            ld_ready_o;
    logic            rf_wen_o;
    logic [4:0]      rf_rd_o;
    logic [XLEN-1:0] rf_wdata_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_wen_i, id_is_load_i,
        output ex_valid_i, ex_rd_i, ex_wdata_i, ld_valid_i, ld_data_i,
        input  id_stall_o, ld_ready_o, rf_wen_o, rf_rd_o, rf_wdata_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_wen_i, id_is_load_i,
        input  ex_valid_i, ex_rd_i, ex_wdata_i, ld_valid_i, ld_data_i,
        output id_stall_o, ld_ready_o, rf_wen_o, rf_rd_o, rf_wdata_o
    );

endinterface

// File: rtl/gpr_wb_sched_sb_tag_fifo.sv
// rtl/gpr_wb_sched_sb_tag_fifo.sv - sb_tag_fifo: power-of-two tag FIFO holding destinations of outstanding loads
module sb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gpr_wb_sched.sv
// rtl/gpr_wb_sched.sv - GPR scoreboard and single-port write-back arbiter (execute over load)
// Optional stall-cycle counter output sb_stall_cnt_o under YSYX_23060251_SB_PERF_EN.
module gpr_wb_sched
    import gpr_wb_sched_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int LDQ_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    gpr_wb_sched_if.slave      bus
`ifdef YSYX_23060251_SB_PERF_EN
    ,
    output logic [31:0]        sb_stall_cnt_o
`endif
);
    logic [ysyx_23060251_reg_num-1:1] pending;
    logic [ysyx_23060251_reg_num-1:0] pend_vec;
    logic [ysyx_23060251_reg_num-1:0] set_vec;
    logic [ysyx_23060251_reg_num-1:0] clr_vec;

    ysyx_23060251_rs_bus ldq_head;
    logic                ldq_full;
    logic                ldq_empty;

    logic                stall;
    logic                issue;
    logic                ld_ready;
    logic                ld_accept;

    logic                rf_wen_q;
    ysyx_23060251_rs_bus rf_rd_q;
    logic [XLEN-1:0]     rf_wdata_q;

    assign pend_vec = {pending, 1'b0};

    assign stall = bus.id_valid_i &&
                   (reg_hit(pend_vec, bus.id_rs1_i) ||
                    reg_hit(pend_vec, bus.id_rs2_i) ||
                    (bus.id_wen_i && reg_hit(pend_vec, bus.id_rd_i)) ||
                    (bus.id_is_load_i && ldq_full));
    assign issue = bus.id_valid_i && !stall;

    assign ld_ready  = !ldq_empty && !bus.ex_valid_i;
    assign ld_accept = bus.ld_valid_i && ld_ready;

    assign bus.id_stall_o = stall;
    assign bus.ld_ready_o = ld_ready;
    assign bus.rf_wen_o   = rf_wen_q;
    assign bus.rf_rd_o    = rf_rd_q;
    assign bus.rf_wdata_o = rf_wdata_q;

    // Loads to x0 are still queued so their return is drained in order.
    sb_tag_fifo #(
        .DEPTH (LDQ_DEPTH),
        .WIDTH (5)
    ) u_tag_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (issue && bus.id_is_load_i),
        .push_data (bus.id_rd_i),
        .pop       (ld_accept),
        .head      (ldq_head),
        .full      (ldq_full),
        .empty     (ldq_empty)
    );

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue && bus.id_wen_i && (bus.id_rd_i != ysyx_23060251_reg_zero))
            set_vec[bus.id_rd_i] = 1'b1;
        if (rf_wen_q)
            clr_vec[rf_rd_q] = 1'b1;
    end

    // Clearing on the commit edge keeps dependents issuing exactly when regs holds the value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec[ysyx_23060251_reg_num-1:1]) |
                       set_vec[ysyx_23060251_reg_num-1:1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= ysyx_23060251_reg_zero;
            rf_wdata_q <= '0;
        end else if (bus.ex_valid_i) begin
            rf_wen_q   <= (bus.ex_rd_i != ysyx_23060251_reg_zero);
            rf_rd_q    <= bus.ex_rd_i;
            rf_wdata_q <= bus.ex_wdata_i;
        end else if (ld_accept) begin
            rf_wen_q   <= (ldq_head != ysyx_23060251_reg_zero);
            rf_rd_q    <= ldq_head;
            rf_wdata_q <= bus.ld_data_i;
        end else begin
            rf_wen_q   <= 1'b0;
        end
    end

`ifdef YSYX_23060251_SB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sb_stall_cnt_o <= '0;
        end else if (stall) begin
            sb_stall_cnt_o <= sb_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gpr_wb_sched.sv
// tb/tb_gpr_wb_sched.sv - directed self-checking bench for gpr_wb_sched
module tb_gpr_wb_sched;
    localparam int XLEN = 64;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    gpr_wb_sched_if #(.XLEN(XLEN)) bus ();

`ifdef YSYX_23060251_SB_PERF_EN
    logic [31:0] stall_cnt;
`endif

    gpr_wb_sched #(
        .XLEN      (XLEN),
        .LDQ_DEPTH (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
`ifdef YSYX_23060251_SB_PERF_EN
        ,
        .sb_stall_cnt_o (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid_i   = 1'b0;
        bus.id_rs1_i     = 5'd0;
        bus.id_rs2_i     = 5'd0;
        bus.id_rd_i      = 5'd0;
        bus.id_wen_i     = 1'b0;
        bus.id_is_load_i = 1'b0;
        bus.ex_valid_i   = 1'b0;
        bus.ex_rd_i      = 5'd0;
        bus.ex_wdata_i   = '0;
        bus.ld_valid_i   = 1'b0;
        bus.ld_data_i    = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rd,
                         input logic wen, input logic is_load);
        bus.id_valid_i   = 1'b1;
        bus.id_rs1_i     = rs1;
        bus.id_rs2_i     = 5'd0;
        bus.id_rd_i      = rd;
        bus.id_wen_i     = wen;
        bus.id_is_load_i = is_load;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;

        // reset with random inputs
        bus.id_valid_i   = 1'b1;
        bus.id_rs1_i     = 5'($urandom);
        bus.id_rs2_i     = 5'($urandom);
        bus.id_rd_i      = 5'($urandom);
        bus.id_wen_i     = 1'b1;
        bus.id_is_load_i = 1'b1;
        bus.ex_valid_i   = 1'b1;
        bus.ex_rd_i      = 5'($urandom);
        bus.ex_wdata_i   = {$urandom, $urandom};
        bus.ld_valid_i   = 1'b1;
        bus.ld_data_i    = {$urandom, $urandom};
        tick();
        tick();
        check("rst_rf_wen",   64'(bus.rf_wen_o),   64'd0);
        check("rst_rf_rd",    64'(bus.rf_rd_o),    64'd0);
        check("rst_rf_wdata", bus.rf_wdata_o,      64'd0);
        check("rst_stall",    64'(bus.id_stall_o), 64'd0);
        check("rst_ld_ready", 64'(bus.ld_ready_o), 64'd0);

        idle();
        rst = 1'b1;
        tick();
        issue(5'd7, 5'd0, 1'b0, 1'b0);
        #1;
        check("post_rst_rs1_7", 64'(bus.id_stall_o), 64'd0);
        tick();

        // ALU RAW
        issue(5'd0, 5'd5, 1'b1, 1'b0);
        #1;
        check("raw_prod_issue", 64'(bus.id_stall_o), 64'd0);
        tick();
        issue(5'd5, 5'd0, 1'b0, 1'b0);
        #1;
        check("raw_stall_0", 64'(bus.id_stall_o), 64'd1);
        tick();
        check("raw_stall_1", 64'(bus.id_stall_o), 64'd1);
        bus.ex_valid_i = 1'b1;
        bus.ex_rd_i    = 5'd5;
        bus.ex_wdata_i = 64'h1234;
        #1;
        check("raw_stall_ex", 64'(bus.id_stall_o), 64'd1);
        tick();
        bus.ex_valid_i = 1'b0;
        #1;
        check("raw_rf_wen",   64'(bus.rf_wen_o), 64'd1);
        check("raw_rf_rd",    64'(bus.rf_rd_o),  64'd5);
        check("raw_rf_wdata", bus.rf_wdata_o,    64'h1234);
        check("raw_stall_commit", 64'(bus.id_stall_o), 64'd1);
        tick();
        check("raw_stall_drop", 64'(bus.id_stall_o), 64'd0);
        check("raw_rf_wen_off", 64'(bus.rf_wen_o),   64'd0);
        tick();
        idle();

        // load limit
        for (int i = 1; i <= 4; i++) begin
            issue(5'd0, 5'(i), 1'b1, 1'b1);
            #1;
            check("ld_fill_stall", 64'(bus.id_stall_o), 64'd0);
            tick();
        end
        issue(5'd0, 5'd6, 1'b1, 1'b1);
        #1;
        check("ld_5th_stall", 64'(bus.id_stall_o), 64'd1);
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 64'hDEAD;
        #1;
        check("ld_ready_full", 64'(bus.ld_ready_o), 64'd1);
        tick();
        bus.ld_valid_i = 1'b0;
        #1;
        check("ld_rf_wen",   64'(bus.rf_wen_o), 64'd1);
        check("ld_rf_rd",    64'(bus.rf_rd_o),  64'd1);
        check("ld_rf_wdata", bus.rf_wdata_o,    64'hDEAD);
        check("ld_5th_go",   64'(bus.id_stall_o), 64'd0);
        tick();
        idle();
        do_reset();

        // execute/load collision
        issue(5'd0, 5'd4, 1'b1, 1'b1);
        tick();
        idle();
        bus.ex_valid_i = 1'b1;
        bus.ex_rd_i    = 5'd3;
        bus.ex_wdata_i = 64'hAA;
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 64'hBB;
        #1;
        check("col_ld_ready", 64'(bus.ld_ready_o), 64'd0);
        tick();
        bus.ex_valid_i = 1'b0;
        #1;
        check("col_ex_rd",    64'(bus.rf_rd_o),  64'd3);
        check("col_ex_wdata", bus.rf_wdata_o,    64'hAA);
        check("col_ld_ready2", 64'(bus.ld_ready_o), 64'd1);
        tick();
        bus.ld_valid_i = 1'b0;
        #1;
        check("col_ld_wen",   64'(bus.rf_wen_o), 64'd1);
        check("col_ld_rd",    64'(bus.rf_rd_o),  64'd4);
        check("col_ld_wdata", bus.rf_wdata_o,    64'hBB);
        tick();
        check("col_ld_ready_end", 64'(bus.ld_ready_o), 64'd0);

        // load to x0
        issue(5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        check("x0_issue_stall", 64'(bus.id_stall_o), 64'd0);
        tick();
        idle();
        #1;
        check("x0_ld_ready", 64'(bus.ld_ready_o), 64'd1);
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 64'h55;
        tick();
        bus.ld_valid_i = 1'b0;
        #1;
        check("x0_rf_wen",   64'(bus.rf_wen_o),   64'd0);
        check("x0_popped",   64'(bus.ld_ready_o), 64'd0);
        issue(5'd0, 5'd0, 1'b1, 1'b0);
        #1;
        check("x0_no_stall", 64'(bus.id_stall_o), 64'd0);
        tick();
        idle();

        // stray return with empty queue
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 64'h66;
        tick();
        check("empty_ld_no_wen", 64'(bus.rf_wen_o), 64'd0);
        idle();

        // async reset mid-flight
        issue(5'd0, 5'd8, 1'b1, 1'b1);
        tick();
        issue(5'd0, 5'd9, 1'b1, 1'b1);
        tick();
        issue(5'd8, 5'd0, 1'b0, 1'b0);
        #1;
        check("mf_pre_stall",    64'(bus.id_stall_o), 64'd1);
        check("mf_pre_ld_ready", 64'(bus.ld_ready_o), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mf_rst_stall",    64'(bus.id_stall_o), 64'd0);
        check("mf_rst_ld_ready", 64'(bus.ld_ready_o), 64'd0);
        #2;
        rst = 1'b1;
        idle();
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 64'h77;
        tick();
        check("mf_no_wen_0", 64'(bus.rf_wen_o), 64'd0);
        tick();
        check("mf_no_wen_1", 64'(bus.rf_wen_o), 64'd0);
        check("mf_ld_ready", 64'(bus.ld_ready_o), 64'd0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
